// File: rtl/yarvi_pkg.sv
// Shared definitions for the yarvi transmit arbiter: arbiter state encoding
// and the width of one channel byte.
package yarvi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/yarvi_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of `valid`
// found when scanning circularly upward from `ptr`, plus a flag telling
// whether any bit was set at all. `ptr` is assumed to be below N.
module yarvi_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [W:0] pos;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (W + 1)'(k);
            if (pos >= (W + 1)'(N)) begin
                pos = pos - (W + 1)'(N);
            end
            if (valid[pos[W-1:0]]) begin
                idx = pos[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yarvi_tx_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte channel among NREQ
// requesters. A grant is held for a whole packet (until a byte flagged
// last is accepted); one registered output stage drives the channel.
// Optional feature macro: YARVI_TXARB_STALL_RELEASE_EN -- when defined, a
// lock whose owner stays silent for STALL_LIMIT cycles is force-released
// and the stall_release output pulses for one cycle.
module yarvi_tx_arbiter
    import yarvi_pkg::*;
#(
    parameter  int NREQ        = 2,
    parameter  int STALL_LIMIT = 255,
    localparam int GW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx_valid,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_ready,
    output logic [GW-1:0]          grant_id
`ifdef YARVI_TXARB_STALL_RELEASE_EN
    ,
    output logic                   stall_release
`endif
);

    if (NREQ < 2 || NREQ > 8 || STALL_LIMIT < 1) begin : g_bad_params
        $error("yarvi_tx_arbiter: NREQ must be 2..8 and STALL_LIMIT >= 1");
    end

    arb_state_t        state, state_next;
    logic [GW-1:0]     rr_ptr, ptr_next, grant_next;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic              beat;
    logic              stall_hit;
    logic [BYTE_W-1:0] sel_data;
    logic              sel_last;

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        if (g == GW'(NREQ - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    yarvi_rr_pick #(
        .N(NREQ),
        .W(GW)
    ) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Owner's byte/last mux and the ready handshake back to the owner only.
    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == grant_id) begin
                sel_data = req_data[i*BYTE_W +: BYTE_W];
                sel_last = req_last[i];
                if (state == LOCKED) begin
                    req_ready[i] = req_valid[i] & (~tx_valid | tx_ready);
                end
            end
        end
    end

    assign beat = |req_ready;

`ifdef YARVI_TXARB_STALL_RELEASE_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stall_cnt;
    logic          sel_valid;

    assign sel_valid = |(req_valid & req_ready) | req_valid[grant_id];
    assign stall_hit = (state == LOCKED) && !sel_valid &&
                       (stall_cnt == SW'(STALL_LIMIT - 1));

    // Count silent cycles of the current owner; any accepted beat restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt     <= '0;
            stall_release <= 1'b0;
        end else begin
            stall_release <= stall_hit;
            if (state != LOCKED || beat || stall_hit) begin
                stall_cnt <= '0;
            end else if (!sel_valid) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, release on the last byte (or stall).
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        ptr_next   = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_idx;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if ((beat && sel_last) || stall_hit) begin
                    state_next = IDLE;
                    ptr_next   = next_ptr(grant_id);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, current owner and rotation pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= ptr_next;
        end
    end

    // Output register: load on an accepted beat, empty when drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (beat) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_yarvi_tx_arbiter.sv
// Directed testbench for yarvi_tx_arbiter (default build, NREQ=2 and NREQ=3).
module tb_yarvi_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic [0:0]  grant_id;

    logic [2:0]  rv3 = '0;
    logic [23:0] rd3 = '0;
    logic [2:0]  rl3 = '0;
    logic [2:0]  rr3;
    logic        tv3;
    logic [7:0]  td3;
    logic        tr3 = 1'b0;
    logic [1:0]  gid3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] srcq0[$];
    logic [8:0] srcq1[$];
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [1:0] hold = '0;

    always #5 clock = ~clock;

    yarvi_tx_arbiter #(.NREQ(2), .STALL_LIMIT(255)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id)
    );

    yarvi_tx_arbiter #(.NREQ(3), .STALL_LIMIT(255)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(rv3), .req_data(rd3), .req_last(rl3),
        .req_ready(rr3),
        .tx_valid(tv3), .tx_data(td3), .tx_ready(tr3),
        .grant_id(gid3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < txq.size()) check_eq(tag, {24'h0, txq[i]}, {24'h0, expq[i]});
        end
    endtask

    task automatic drive();
        req_valid[0]  = !hold[0] && srcq0.size() > 0;
        req_data[7:0] = (srcq0.size() > 0) ? srcq0[0][7:0] : 8'h00;
        req_last[0]   = (srcq0.size() > 0) ? srcq0[0][8] : 1'b0;
        req_valid[1]  = !hold[1] && srcq1.size() > 0;
        req_data[15:8] = (srcq1.size() > 0) ? srcq1[0][7:0] : 8'h00;
        req_last[1]   = (srcq1.size() > 0) ? srcq1[0][8] : 1'b0;
    endtask

    // One clock: sample handshakes at negedge, advance sources after posedge.
    task automatic step();
        logic [1:0] acc;
        @(negedge clock);
        acc = req_valid & req_ready;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        @(posedge clock);
        #1;
        if (acc[0]) void'(srcq0.pop_front());
        if (acc[1]) void'(srcq1.pop_front());
        drive();
        #1;
    endtask

    int first_k;
    int seen;
    logic [1:0] gseq[4];
    logic [7:0] tseq[4];
    int ng, nt;

    initial begin
        // Reset state
        #3;
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_req_ready", req_ready, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        step();

        // Single requester: 48 69 0A(last)
        srcq0 = '{9'h048, 9'h069, 9'h10A};
        drive(); #1;
        check_eq("a_arb_no_ready", req_ready, 0);
        first_k = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (first_k == 0 && txq.size() > 0) first_k = k;
        end
        check_eq("a_latency", first_k, 3);
        expq = '{8'h48, 8'h69, 8'h0A};
        check_stream("a_bytes");
        check_eq("a_drained", tx_valid, 0);
        txq.delete();

        // Both continuously valid; pointer now favours requester 1
        srcq0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
        srcq1 = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
        drive();
        for (int k = 0; k < 40 && txq.size() < 8; k++) step();
        expq = '{8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hB2, 8'hB3, 8'hA2, 8'hA3};
        check_stream("b_order");
        for (int k = 0; k < 3; k++) step();
        txq.delete();

        // Channel stall mid-packet
        srcq1 = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
        drive();
        for (int k = 0; k < 10 && txq.size() < 1; k++) step();
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("c_hold_valid", tx_valid, 1);
            check_eq("c_hold_data", tx_data, 8'hC1);
            check_eq("c_hold_ready", req_ready, 0);
        end
        tx_ready = 1'b1;
        for (int k = 0; k < 20 && txq.size() < 4; k++) step();
        expq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        check_stream("c_bytes");
        for (int k = 0; k < 3; k++) step();
        txq.delete();

        // Owner goes silent; other requester must wait
        srcq1 = '{9'h0D0, 9'h0D1, 9'h1D2};
        drive();
        for (int k = 0; k < 10 && srcq1.size() > 2; k++) step();
        hold[1] = 1'b1;
        srcq0 = '{9'h1E0};
        drive(); #1;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (req_ready[0]) seen++;
        end
        check_eq("d_starve", seen, 0);
        check_eq("d_grant_held", grant_id, 1);
        check_eq("d_one_out", txq.size(), 1);
        hold[1] = 1'b0;
        drive();
        for (int k = 0; k < 20 && txq.size() < 4; k++) step();
        expq = '{8'hD0, 8'hD1, 8'hD2, 8'hE0};
        check_stream("d_bytes");
        for (int k = 0; k < 3; k++) step();
        txq.delete();

        // Asynchronous reset with a byte in flight
        srcq0 = '{9'h0F0, 9'h0F1, 9'h1F2};
        drive();
        for (int k = 0; k < 10 && !tx_valid; k++) step();
        tx_ready = 1'b0;
        #1;
        check_eq("e_inflight", tx_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("e_rst_tx_valid", tx_valid, 0);
        check_eq("e_rst_tx_data", tx_data, 0);
        check_eq("e_rst_ready", req_ready, 0);
        check_eq("e_rst_grant", grant_id, 0);
        srcq0.delete();
        txq.delete();
        tx_ready = 1'b1;
        drive();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        srcq1 = '{9'h1AB};
        drive(); #1;
        check_eq("e_idle_ready", req_ready, 0);
        step();
        check_eq("e_grant1", grant_id, 1);
        check_eq("e_ready1", req_ready, 2'b10);
        for (int k = 0; k < 10 && txq.size() < 1; k++) step();
        expq = '{8'hAB};
        check_stream("e_bytes");

        // NREQ=3 rotation with single-byte packets
        rd3 = {8'hC2, 8'hC1, 8'hC0};
        rl3 = 3'b111;
        tr3 = 1'b1;
        rv3 = 3'b111;
        ng = 0;
        nt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (|rr3 && ng < 4) begin gseq[ng] = gid3; ng++; end
            if (tv3 && nt < 4) begin tseq[nt] = td3; nt++; end
        end
        check_eq("f_ngrants", ng, 4);
        check_eq("f_g0", gseq[0], 0);
        check_eq("f_g1", gseq[1], 1);
        check_eq("f_g2", gseq[2], 2);
        check_eq("f_g3", gseq[3], 0);
        check_eq("f_ntx", nt, 4);
        check_eq("f_t0", tseq[0], 8'hC0);
        check_eq("f_t1", tseq[1], 8'hC1);
        check_eq("f_t2", tseq[2], 8'hC2);
        check_eq("f_t3", tseq[3], 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
